pll_lock_supervisor: RTL

- Drives the reset input of a PLL wrapper and consumes its asynchronous `locked` output.
- Controls the PLL reset, qualifies lock over a stable window, and retries a bounded number of times after lock timeouts.
- Generates the downstream system reset. Lock loss at runtime triggers a relock.
- Clocked from the PLL reference clock (free-running), never from a PLL output.

---
 rtl/pll_supervisor_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared state encoding and sizing helpers for the PLL lock supervisor.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAIL
  } pll_state_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // One shared counter must reach (max parameter - 1).
  function automatic int cnt_width(input int rst_cycles, input int timeout_cycles,
                                   input int stable_cycles);
    int m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs, cleared to 0 by reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock qualification with bounded retries and system reset generation.
// Runs on the free-running reference clock; pll_locked is asynchronous and synchronized here.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_ok,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  // state     | meaning
  // RESET_PLL | PLL held in reset for PLL_RST_CYCLES
  // WAIT_LOCK | PLL released, waiting for lock within the timeout window
  // STABILIZE | lock seen, must hold for LOCK_STABLE_CYCLES consecutive cycles
  // RUN       | lock qualified, system reset released
  // FAIL      | retries exhausted, waiting for force_relock

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  pll_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          first_q;
  logic          pll_rst_q;
  logic          sys_reset_n_q;
  logic          lock_ok_q;
  logic          fail_q;
  logic [3:0]    retry_q;
  logic [7:0]    loss_q;
  logic [7:0]    loss_d;
  logic          locked_s;

  sync_2ff u_lock_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  (pll_locked),
    .q_o  (locked_s)
  );

  assign cnt_d  = cnt_q + CW'(1);
  assign loss_d = (loss_q == LOSS_CNT_MAX) ? loss_q : loss_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lock_ok_q     <= 1'b0;
      fail_q        <= 1'b0;
      retry_q       <= 4'd0;
      loss_q        <= 8'd0;
    end else begin
      first_q <= 1'b0;
      cnt_q   <= cnt_d;
      case (state_q)
        RESET_PLL: begin
          // The reset-release edge acts as the entry edge, so the first attempt is full length.
          if (first_q) begin
            cnt_q <= '0;
          end else if (cnt_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (force_relock) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
          end else if (locked_s) begin
            state_q <= STABILIZE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_q <= '0;
            if (retry_q == RETRY_LIMIT) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q   <= RESET_PLL;
              pll_rst_q <= 1'b1;
              retry_q   <= retry_q + 4'd1;
            end
          end
        end
        STABILIZE: begin
          if (force_relock) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
          end else if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            sys_reset_n_q <= 1'b1;
            lock_ok_q     <= 1'b1;
            retry_q       <= 4'd0;
          end
        end
        RUN: begin
          if (!locked_s || force_relock) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            lock_ok_q     <= 1'b0;
            if (!locked_s) loss_q <= loss_d;
          end
        end
        FAIL: begin
          if (force_relock) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            fail_q    <= 1'b0;
            retry_q   <= 4'd0;
          end
        end
        default: begin
          state_q       <= RESET_PLL;
          cnt_q         <= '0;
          pll_rst_q     <= 1'b1;
          sys_reset_n_q <= 1'b0;
          lock_ok_q     <= 1'b0;
          fail_q        <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign lock_ok         = lock_ok_q;
  assign fail            = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule
